// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC responder: FSM states, command length, default width.
package spi_adc_pkg;

  localparam int CMD_BITS       = 3;
  localparam int DEFAULT_DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    NULL_BIT,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, followed by an edge-detect register.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating a two-channel serial ADC: decodes start/SGL/ODD/MSBF
// and shifts the selected parallel sample out on miso, MSB-first with optional LSB-first tail.
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_en,
  input  logic [DATA_W-1:0] sample_ch0,
  input  logic [DATA_W-1:0] sample_ch1,
  output logic              cmd_valid,
  output logic              cmd_sgl,
  output logic              cmd_odd,
  output logic              cmd_msbf,
  output logic              frame_done
);

  localparam int         FLUSH_W   = SYNC_STAGES + 1;
  localparam logic [4:0] W5        = 5'(DATA_W);
  localparam logic [4:0] TERM_MSBF = 5'(DATA_W);
  localparam logic [4:0] TERM_LSBF = 5'(2 * DATA_W - 1);
  localparam logic [1:0] CNT_LAST  = 2'(CMD_BITS - 1);

  // Sent-bit count n selects D[W-1-n] on the MSB-first leg, D[n-W+1] on the LSB-first tail.
  function automatic logic [DATA_W-1:0] bit_mask(input logic [4:0] n);
    return DATA_W'(1) << ((n < W5) ? (W5 - 5'd1 - n) : (n - W5 + 5'd1));
  endfunction

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // Stage p0: synchronise asynchronous pins and detect edges.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .din(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .din(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_edges;
  assign unused_edges = &{1'b0, sck_lvl, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_t              state_q, state_nxt;
  logic [1:0]          cmd_cnt_q, cmd_cnt_nxt;
  logic                sgl_q, sgl_nxt, odd_q, odd_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [4:0]          bit_cnt_q, bit_cnt_nxt;
  logic [FLUSH_W-1:0]  flush_q;
  logic                armed_q, armed_nxt;
  logic                miso_nxt, miso_en_nxt, cmd_valid_nxt, frame_done_nxt;
  logic                cmd_sgl_nxt, cmd_odd_nxt, cmd_msbf_nxt;
  logic [4:0]          term;

  // A cs_n low left over from reset looks like a fresh fall; only arm once cs_n is seen high.
  assign armed_nxt = armed_q | (flush_q[FLUSH_W-1] & cs_lvl);
  assign term      = cmd_msbf ? TERM_MSBF : TERM_LSBF;

  // Stage p1: frame state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_cnt_q  <= '0;
      sgl_q      <= 1'b0;
      odd_q      <= 1'b0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      flush_q    <= '0;
      armed_q    <= 1'b0;
      miso       <= 1'b0;
      miso_en    <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      cmd_sgl    <= 1'b0;
      cmd_odd    <= 1'b0;
      cmd_msbf   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cmd_cnt_q  <= cmd_cnt_nxt;
      sgl_q      <= sgl_nxt;
      odd_q      <= odd_nxt;
      data_q     <= data_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      flush_q    <= {flush_q[FLUSH_W-2:0], 1'b1};
      armed_q    <= armed_nxt;
      miso       <= miso_nxt;
      miso_en    <= miso_en_nxt;
      cmd_valid  <= cmd_valid_nxt;
      frame_done <= frame_done_nxt;
      cmd_sgl    <= cmd_sgl_nxt;
      cmd_odd    <= cmd_odd_nxt;
      cmd_msbf   <= cmd_msbf_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    cmd_cnt_nxt    = cmd_cnt_q;
    sgl_nxt        = sgl_q;
    odd_nxt        = odd_q;
    data_nxt       = data_q;
    bit_cnt_nxt    = bit_cnt_q;
    miso_nxt       = miso;
    miso_en_nxt    = miso_en;
    cmd_valid_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    cmd_sgl_nxt    = cmd_sgl;
    cmd_odd_nxt    = cmd_odd;
    cmd_msbf_nxt   = cmd_msbf;

    if (state_q != IDLE && cs_lvl) begin
      state_nxt   = IDLE;
      miso_nxt    = 1'b0;
      miso_en_nxt = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_nxt    = 1'b0;
          miso_en_nxt = 1'b0;
          if (armed_q && !cs_lvl) begin
            state_nxt   = WAIT_START;
            cmd_cnt_nxt = '0;
            bit_cnt_nxt = '0;
          end
        end
        WAIT_START: begin
          if (sck_rise && mosi_lvl) begin
            state_nxt   = CMD;
            cmd_cnt_nxt = '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            if (cmd_cnt_q == CNT_LAST) begin
              cmd_sgl_nxt   = sgl_q;
              cmd_odd_nxt   = odd_q;
              cmd_msbf_nxt  = mosi_lvl;
              data_nxt      = odd_q ? sample_ch1 : sample_ch0;
              cmd_valid_nxt = 1'b1;
              bit_cnt_nxt   = '0;
              state_nxt     = NULL_BIT;
            end else begin
              if (cmd_cnt_q == 2'd0) sgl_nxt = mosi_lvl;
              else                   odd_nxt = mosi_lvl;
              cmd_cnt_nxt = cmd_cnt_q + 2'd1;
            end
          end
        end
        NULL_BIT: begin
          if (sck_fall) begin
            if (!miso_en) begin
              miso_en_nxt = 1'b1;
              miso_nxt    = 1'b0;
            end else begin
              state_nxt   = DATA;
              miso_nxt    = data_q[DATA_W-1];
              bit_cnt_nxt = 5'd1;
            end
          end
        end
        DATA: begin
          if (sck_fall) begin
            if (bit_cnt_q == term) begin
              state_nxt      = DONE;
              miso_nxt       = 1'b0;
              frame_done_nxt = 1'b1;
            end else begin
              miso_nxt    = |(data_q & bit_mask(bit_cnt_q));
              bit_cnt_nxt = bit_cnt_q + 5'd1;
            end
          end
        end
        DONE: begin
          miso_nxt    = 1'b0;
          miso_en_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: an SPI master drives frames, a bit-sequence model
// predicts miso, and a compare process checks the outputs in each settled sck-low window.
module tb_spi_adc_responder;

  localparam int W    = 12;
  localparam int S    = 2;
  localparam int L    = S + 1;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sck, cs_n, mosi;
  logic         miso, miso_en;
  logic [W-1:0] sample_ch0, sample_ch1;
  logic         cmd_valid, cmd_sgl, cmd_odd, cmd_msbf, frame_done;

  int checks   = 0;
  int failures = 0;
  int n_cv     = 0;
  int n_fd     = 0;

  logic win = 1'b0, win_first = 1'b0, exp_miso = 1'b0, exp_fd = 1'b0;
  logic exp_bits[$];

  spi_adc_responder #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_en(miso_en), .sample_ch0(sample_ch0), .sample_ch1(sample_ch1),
    .cmd_valid(cmd_valid), .cmd_sgl(cmd_sgl), .cmd_odd(cmd_odd), .cmd_msbf(cmd_msbf),
    .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits seen on miso after each sck fall: null bit, MSB-first word, optional LSB-first tail.
  function automatic void build_model(input logic [W-1:0] d, input logic msbf);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
    if (!msbf) for (int i = 1; i < W; i++) exp_bits.push_back(d[i]);
  endfunction

  function automatic logic [31:0] pack_model();
    logic [31:0] v = '0;
    foreach (exp_bits[i]) v = {v[30:0], exp_bits[i]};
    return v;
  endfunction

  always begin
    @(posedge clk);
    #2;
    if (cmd_valid)  n_cv++;
    if (frame_done) n_fd++;
    if (win) begin
      chk("miso_en", 32'(miso_en), 32'd1);
      chk("miso", 32'(miso), 32'(exp_miso));
      chk("frame_done", 32'(frame_done), 32'(win_first & exp_fd));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd_bit(input logic b);
    sck = 1'b0; mosi = b; tick(HALF);
    sck = 1'b1; tick(HALF);
  endtask

  task automatic data_fall(input int k);
    sck = 1'b0;
    tick(L - 1);
    exp_miso  = (k <= exp_bits.size()) ? exp_bits[k-1] : 1'b0;
    exp_fd    = (k == exp_bits.size() + 1);
    win       = 1'b1;
    win_first = 1'b1;
    tick(1);
    win_first = 1'b0;
    tick(HALF - L);
    win = 1'b0;
    sck = 1'b1;
    tick(HALF);
  endtask

  task automatic frame(input int nz, input logic sgl, input logic odd, input logic msbf,
                       input logic [W-1:0] d, input int abort_falls, input bit change_ch0);
    int cv0, fd0, nf;
    cv0 = n_cv;
    fd0 = n_fd;
    build_model(d, msbf);
    cs_n = 1'b0; tick(HALF);
    repeat (nz) cmd_bit(1'b0);
    cmd_bit(1'b1); cmd_bit(sgl); cmd_bit(odd); cmd_bit(msbf);
    if (change_ch0) sample_ch0 = 12'h123;
    nf = (abort_falls > 0) ? abort_falls : exp_bits.size() + 1;
    for (int k = 1; k <= nf; k++) data_fall(k);
    cs_n = 1'b1;
    tick(S + 2);
    chk("cs_high_miso_en", 32'(miso_en), 32'd0);
    chk("cs_high_miso", 32'(miso), 32'd0);
    sck = 1'b0; mosi = 1'b0; tick(HALF);
    chk("cmd_valid_count", 32'(n_cv - cv0), 32'd1);
    chk("frame_done_count", 32'(n_fd - fd0), (abort_falls > 0) ? 32'd0 : 32'd1);
    chk("cmd_sgl", 32'(cmd_sgl), 32'(sgl));
    chk("cmd_odd", 32'(cmd_odd), 32'(odd));
    chk("cmd_msbf", 32'(cmd_msbf), 32'(msbf));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_miso_en"}, 32'(miso_en), 32'd0);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_cmd_sgl"}, 32'(cmd_sgl), 32'd0);
    chk({tag, "_cmd_odd"}, 32'(cmd_odd), 32'd0);
    chk({tag, "_cmd_msbf"}, 32'(cmd_msbf), 32'd0);
  endtask

  initial begin
    int fd0;
    reset = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    sample_ch0 = '0; sample_ch1 = '0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(10);

    build_model(12'hA5C, 1'b1);
    chk("model_msbf_len", 32'(exp_bits.size()), 32'd13);
    chk("model_msbf_bits", pack_model(), 32'h0000_0A5C);
    build_model(12'h801, 1'b0);
    chk("model_lsbf_len", 32'(exp_bits.size()), 32'd24);
    chk("model_lsbf_bits", pack_model(), 32'h0040_0801);

    sample_ch0 = 12'hA5C; sample_ch1 = 12'h3C3;
    frame(0, 1'b1, 1'b0, 1'b1, 12'hA5C, 0, 1'b0);

    sample_ch0 = 12'h3C3; sample_ch1 = 12'h801;
    frame(0, 1'b1, 1'b1, 1'b0, 12'h801, 0, 1'b0);

    sample_ch0 = 12'hA5C;
    frame(3, 1'b1, 1'b0, 1'b1, 12'hA5C, 0, 1'b0);

    sample_ch0 = 12'h5A5; sample_ch1 = 12'h6E1;
    frame(0, 1'b1, 1'b0, 1'b1, 12'h5A5, 6, 1'b0);
    frame(0, 1'b0, 1'b1, 1'b1, 12'h6E1, 0, 1'b0);

    sample_ch0 = 12'hA5C;
    frame(0, 1'b1, 1'b0, 1'b1, 12'hA5C, 0, 1'b1);

    sample_ch0 = 12'hA5C;
    fd0 = n_fd;
    build_model(12'hA5C, 1'b1);
    cs_n = 1'b0; tick(HALF);
    cmd_bit(1'b1); cmd_bit(1'b1); cmd_bit(1'b0); cmd_bit(1'b1);
    for (int k = 1; k <= 4; k++) data_fall(k);
    reset = 1'b1;
    tick(1);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    repeat (6) begin
      sck = 1'b0; mosi = 1'b1; tick(HALF);
      chk("post_reset_miso_en", 32'(miso_en), 32'd0);
      sck = 1'b1; tick(HALF);
      chk("post_reset_miso_en", 32'(miso_en), 32'd0);
    end
    chk("post_reset_frame_done_count", 32'(n_fd - fd0), 32'd0);
    sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    tick(10);

    sample_ch1 = 12'h9F0;
    frame(1, 1'b0, 1'b1, 1'b0, 12'h9F0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 Parameter DATA_W, default 12, sample width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on sck, cs_n and mosi.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sck  input  1  SPI clock from the master, asynchronous to clk; idle low (mode 0,0).
REQ-006 cs_n  input  1  active-low frame select from the master, asynchronous.
REQ-007 mosi  input  1  command bits from the master, sampled on sck rising edges.
REQ-008 miso  output  1  conversion data to the master, changed after sck falling edges.
REQ-009 miso_en  output  1  high while miso is driven (board-level tristate control).
REQ-010 sample_ch0  input  DATA_W  parallel sample for channel 0.
REQ-011 sample_ch1  input  DATA_W  parallel sample for channel 1.
REQ-012 cmd_valid  output  1  one-clk pulse when a full command has been decoded.
REQ-013 cmd_sgl, cmd_odd, cmd_msbf  output  1 each  decoded command fields; hold until the next command.
REQ-014 frame_done  output  1  one-clk pulse when the last data bit has been shifted out.

Function
REQ-015 sck, cs_n and mosi SHALL pass through SYNC_STAGES flip-flops, then one edge-detect register; edges are detected on the synchronised signals only.
REQ-016 The master SHALL keep each sck phase at least 4 clk periods; faster sck is out of scope.
REQ-017 States: IDLE, WAIT_START, CMD, NULL_BIT, DATA, DONE.
REQ-018 IDLE: miso=0, miso_en=0; a synchronised cs_n=0 moves the FSM to WAIT_START.
REQ-019 WAIT_START: on each sck rise, mosi=1 moves to CMD; mosi=0 stays (leading zeros are ignored).
REQ-020 CMD: on 3 consecutive sck rises, capture SGL, ODD and MSBF in that order.
REQ-021 On the third CMD rise, latch sample_ch1 if ODD=1, else sample_ch0, into a DATA_W shift register.
REQ-022 On the same cycle, pulse cmd_valid, update the cmd_* outputs, and move to NULL_BIT.
REQ-023 NULL_BIT: on the next sck fall, miso=0 and miso_en=1; the following sck fall enters DATA and drives D[DATA_W-1].
REQ-024 DATA: each sck fall drives the next bit MSB-first down to D0.
REQ-025 If MSBF=0, D0 is followed by D1..D[DATA_W-1], LSB-first, without repeating D0.
REQ-026 The sck fall after the last bit moves to DONE, with a frame_done pulse in that cycle.
REQ-027 DONE: miso=0 and miso_en=1 until cs_n rises.
REQ-028 Latency: miso changes exactly SYNC_STAGES+1 clk cycles after the sck fall at the pin.
REQ-029 A synchronised cs_n rise in any state SHALL force IDLE next cycle, with miso=0 and miso_en=0.
REQ-030 An aborted frame SHALL NOT pulse frame_done; cmd_* keep their last values.
REQ-031 cs_n falling again in the cycle after an abort SHALL start a new frame normally.
REQ-032 An sck edge seen while the synchronised cs_n=1 SHALL be ignored.
REQ-033 Bit counter: 5 bits, counts sent data bits; terminal count is DATA_W (MSBF=1) or 2*DATA_W-1 (MSBF=0).
REQ-034 Sample inputs are read only at the latch cycle in REQ-021; later changes do not affect the frame in progress.

Reset
REQ-035 reset=1 SHALL force on the next clk edge: IDLE; miso, miso_en, cmd_valid, frame_done, cmd_sgl, cmd_odd, cmd_msbf = 0.
REQ-036 Reset SHALL also force: shift register and bit counter = 0; synchronisers = idle values (sck=0, cs_n=1, mosi=0).
REQ-037 Reset mid-frame SHALL abandon the frame; the responder waits for a fresh cs_n fall.

Structure
REQ-038 A shared package spi_adc_pkg SHALL hold the state enumeration, CMD_BITS=3, and the default DATA_W.
REQ-039 One sub-module, spi_sync_edge, SHALL hold the synchroniser and edge detector (outputs: level, rise, fall); it is instantiated for sck, cs_n and mosi.

Verification
REQ-040 ch0=0xA5C, frame start,1,0,1 (ch0, MSBF) -> miso = 0 then 1010_0101_1100; frame_done after 13 falls.
REQ-041 ch1=0x801, start,1,1,0 (ch1, LSB-first) -> miso = 0, 1000_0000_0001, then 0000_0000_001; frame_done after 24 falls.
REQ-042 Leading zeros 0,0,0 before the start bit -> same result as REQ-040; cmd_valid pulses exactly once.
REQ-043 cs_n raised after 5 data bits -> IDLE and miso_en=0 within SYNC_STAGES+2 clks; no frame_done; the next frame is correct.
REQ-044 ch0 changed from 0xA5C to 0x123 after the latch -> the frame still returns 0xA5C.
REQ-045 reset pulsed during DATA -> all outputs 0 next cycle; sck toggling with cs_n low but no new fall -> miso_en stays 0.
